image_read: RTL and testbench
=============================

Name: image_read

Overview:
- Frame source for the image pipeline: holds one 24-bit BMP pixel array in memory and streams it out two pixels per clock.
- Output format is what image_write consumes: per-row HSYNC bursts carrying an odd/even pixel pair (R0/G0/B0, R1/G1/B1).
- Emits a VSYNC preamble, then rows top-to-bottom, then a done flag.
- Sits at the head of the simulation pipeline, ahead of processing blocks and image_write.

Parameters:
- WIDTH, 10, image width in pixels; must be even, >= 2.
- HEIGHT, 5, image height in rows, >= 1.
- INPUT_FILE, "../images/input.hex", hex file of BMP pixel bytes (header stripped), loaded with $readmemh at time 0.
- START_UP_DELAY, 100, VSYNC high duration in cycles, >= 1.
- HSYNC_DELAY, 160, HSYNC-low gap before each row in cycles, >= 1.
- BRIGHTNESS_VALUE, 50, 8-bit unsigned offset; used only with the optional feature.

Ports:
- HCLK  in  1  clock; everything is in this one clock domain.
- HRESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle start request; sampled only in IDLE or DONE.
- VSYNC  out  1  high during the frame preamble.
- HSYNC  out  1  high on cycles carrying a valid pixel pair.
- DATA_R0, DATA_G0, DATA_B0  out  8 each  even pixel (column 2c).
- DATA_R1, DATA_G1, DATA_B1  out  8 each  odd pixel (column 2c+1).
- ctrl_done  out  1  frame complete; sticky.

Behaviour:
- Memory layout:
  - total_memory_bytes = WIDTH*HEIGHT*3, BMP order: bottom row first, bytes B,G,R per pixel.
  - Stream row r (0 = top) and column pair c read from base = WIDTH*3*(HEIGHT-1-r) + 6*c.
  - B0 = mem[base+0], G0 = +1, R0 = +2, B1 = +3, G1 = +4, R1 = +5.
- Reset (async, HRESET=1):
  - State goes to IDLE; all counters clear.
  - VSYNC, HSYNC, ctrl_done and all DATA outputs are 0.
  - Memory contents are not cleared.
- All outputs are registered.
- FSM states IDLE, VSYNC, GAP, DATA, DONE:
  - IDLE: outputs 0. START=1 -> VSYNC next cycle; delay counter = 0.
  - VSYNC: VSYNC=1 for exactly START_UP_DELAY cycles -> GAP; row = 0.
  - GAP: VSYNC=0, HSYNC=0 for exactly HSYNC_DELAY cycles -> DATA; col = 0.
  - DATA:
    - HSYNC=1 for exactly WIDTH/2 consecutive cycles.
    - In each cycle the DATA outputs hold pair (row, col).
    - col increments each cycle.
    - After col = WIDTH/2-1: if row = HEIGHT-1 -> DONE, else row+1 -> GAP.
  - DONE:
    - ctrl_done=1, held until reset or the next START.
    - HSYNC=0; DATA holds the last pair.
    - START=1 -> ctrl_done=0 next cycle and re-enter VSYNC; the frame replays.
- START is ignored in VSYNC, GAP and DATA.
- DATA outputs change only on cycles where HSYNC=1 is driven, and hold otherwise.
- Frame length from the first VSYNC cycle to the first ctrl_done cycle:
  - START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) cycles.
- Counter widths: sized by $clog2 of their maximum plus 1; no wrap occurs within legal parameters.
- Reset mid-frame: immediate return to IDLE with outputs 0; a fresh START begins a full frame from row 0.

Optional Feature:
- IMAGE_READ_BRIGHTNESS_EN defined:
  - Every output byte = min(mem byte + BRIGHTNESS_VALUE, 255), computed at 9 bits and saturated.
  - Timing is unchanged (same cycle as the unmodified path).
- Undefined: raw memory bytes are passed through, and BRIGHTNESS_VALUE is unused.

Test Plan:
- Reset release then START pulse (WIDTH=10, HEIGHT=5, delays 100/160):
  - VSYNC high for 100 cycles.
  - 5 HSYNC bursts of 5 cycles each, each preceded by 160 low cycles.
  - ctrl_done rises at 925 cycles after the first VSYNC cycle.
- Memory mem[i] = i:
  - First HSYNC cycle gives B0=0x78, G0=0x79, R0=0x7A, B1=0x7B, G1=0x7C, R1=0x7D (base 120).
  - Last pair gives base 24: B0=0x18 ... R1=0x1D.
- Loopback into image_write (matching parameters, its reset driven inverted):
  - Output file pixel bytes equal the input hex byte-for-byte.
  - write_done pulses once.
- Assert HRESET during row 2 of DATA:
  - All outputs 0 in the same cycle.
  - START after release restarts at VSYNC.
  - The first HSYNC pair is from row 0 again.
- START pulses during VSYNC and DATA:
  - Timing is identical to the no-extra-pulse run.
  - START in DONE clears ctrl_done next cycle and replays an identical frame.
- With IMAGE_READ_BRIGHTNESS_EN and BRIGHTNESS_VALUE=50:
  - Byte 0x10 -> 0x42.
  - Byte 0xF0 -> 0xFF (saturated).
  - Byte 0xCD -> 0xFF.
  - Without the macro, the same bytes pass through unchanged.

Source files
------------

// File: rtl/image_read.sv
// image_read: BMP pixel-array frame source, two pixels per HSYNC cycle.
// Optional IMAGE_READ_BRIGHTNESS_EN adds a saturating brightness offset.
module image_read #(
   parameter int    WIDTH            = 10,
   parameter int    HEIGHT           = 5,
   parameter string INPUT_FILE       = "../images/input.hex",
   parameter int    START_UP_DELAY   = 100,
   parameter int    HSYNC_DELAY      = 160,
   parameter int    BRIGHTNESS_VALUE = 50
)(
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       START,
   output logic       VSYNC,
   output logic       HSYNC,
   output logic [7:0] DATA_R0,
   output logic [7:0] DATA_G0,
   output logic [7:0] DATA_B0,
   output logic [7:0] DATA_R1,
   output logic [7:0] DATA_G1,
   output logic [7:0] DATA_B1,
   output logic       ctrl_done
);

   localparam int MEM_BYTES = WIDTH * HEIGHT * 3;
   localparam int ROW_BYTES = WIDTH * 3;
   localparam int PAIRS     = WIDTH / 2;
   localparam int DMAX      = (START_UP_DELAY > HSYNC_DELAY) ?
                              START_UP_DELAY : HSYNC_DELAY;
   localparam int DW        = $clog2(DMAX) + 1;
   localparam int RW        = $clog2(HEIGHT) + 1;
   localparam int CW        = $clog2(PAIRS) + 1;
   localparam int AW        = $clog2(MEM_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_GAP, S_DATA, S_DONE
   } state_t;

   logic [7:0]    mem [MEM_BYTES];
   state_t        state, state_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [RW-1:0] row, row_n;
   logic [CW-1:0] col, col_n;
   logic [AW-1:0] addr;
   logic [7:0]    px [6];

   function automatic logic [7:0] adj(input logic [7:0] b);
`ifdef IMAGE_READ_BRIGHTNESS_EN
      logic [8:0] s;
      s = {1'b0, b} + 9'(BRIGHTNESS_VALUE);
      return s[8] ? 8'hFF : s[7:0];
`else
      return b;
`endif
   endfunction

   // Next-state: sequence preamble, per-row gap, pair burst, done.
   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      row_n   = row;
      col_n   = col;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_n = S_VSYNC;
               dcnt_n  = '0;
            end
         end
         S_VSYNC: begin
            if (dcnt == DW'(START_UP_DELAY - 1)) begin
               state_n = S_GAP;
               dcnt_n  = '0;
               row_n   = '0;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         S_GAP: begin
            if (dcnt == DW'(HSYNC_DELAY - 1)) begin
               state_n = S_DATA;
               col_n   = '0;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         S_DATA: begin
            if (col == CW'(PAIRS - 1)) begin
               if (row == RW'(HEIGHT - 1)) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_GAP;
                  row_n   = row + 1'b1;
                  dcnt_n  = '0;
               end
            end else begin
               col_n = col + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Fetch the pair for the upcoming cycle; rows are stored bottom-up.
   always_comb begin
      addr = AW'(ROW_BYTES) * (AW'(HEIGHT - 1) - AW'(row_n))
           + AW'(6) * AW'(col_n);
      for (int i = 0; i < 6; i++) begin
         px[i] = adj(mem[addr + AW'(i)]);
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= S_IDLE;
         dcnt      <= '0;
         row       <= '0;
         col       <= '0;
         VSYNC     <= 1'b0;
         HSYNC     <= 1'b0;
         ctrl_done <= 1'b0;
         DATA_B0   <= '0;
         DATA_G0   <= '0;
         DATA_R0   <= '0;
         DATA_B1   <= '0;
         DATA_G1   <= '0;
         DATA_R1   <= '0;
      end else begin
         state     <= state_n;
         dcnt      <= dcnt_n;
         row       <= row_n;
         col       <= col_n;
         VSYNC     <= (state_n == S_VSYNC);
         HSYNC     <= (state_n == S_DATA);
         ctrl_done <= (state_n == S_DONE);
         if (state_n == S_DATA) begin
            DATA_B0 <= px[0];
            DATA_G0 <= px[1];
            DATA_R0 <= px[2];
            DATA_B1 <= px[3];
            DATA_G1 <= px[4];
            DATA_R1 <= px[5];
         end
      end
   end

endmodule

// File: tb/tb_image_read.sv
// tb_image_read: directed checks of image_read frame timing and data.
// Memory is preloaded hierarchically with a byte ramp.
module tb_image_read;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic       START;
   logic       VSYNC, HSYNC, ctrl_done;
   logic [7:0] DATA_R0, DATA_G0, DATA_B0;
   logic [7:0] DATA_R1, DATA_G1, DATA_B1;

   int nchk = 0;
   int nfail = 0;

   logic [7:0]  tb_mem [150];
   logic [47:0] pairs [$];
   int          vs_cnt, vs_first, hs_cnt, burst_n, done_k, hold_err;
   int          bstart [8];
   int          blen [8];
   logic        done_at0;

   image_read #(
      .WIDTH(10), .HEIGHT(5), .INPUT_FILE(""),
      .START_UP_DELAY(100), .HSYNC_DELAY(160), .BRIGHTNESS_VALUE(50)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .START(START),
      .VSYNC(VSYNC), .HSYNC(HSYNC),
      .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
      .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
      .ctrl_done(ctrl_done)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [7:0] eb(input logic [7:0] b);
`ifdef IMAGE_READ_BRIGHTNESS_EN
      int s;
      s = int'(b) + 50;
      return (s > 255) ? 8'hFF : 8'(s);
`else
      return b;
`endif
   endfunction

   function automatic logic [47:0] exp_pair(input int n);
      int r, c, base;
      r = n / 5;
      c = n % 5;
      base = 30 * (4 - r) + 6 * c;
      return {eb(tb_mem[base]), eb(tb_mem[base+1]), eb(tb_mem[base+2]),
              eb(tb_mem[base+3]), eb(tb_mem[base+4]), eb(tb_mem[base+5])};
   endfunction

   function automatic logic [47:0] cur_pair();
      return {DATA_B0, DATA_G0, DATA_R0, DATA_B1, DATA_G1, DATA_R1};
   endfunction

   task automatic load_ramp();
      for (int i = 0; i < 150; i++) begin
         tb_mem[i] = 8'(i);
         dut.mem[i] = 8'(i);
      end
   endtask

   // Pulse START, then sample every negedge until ctrl_done (k=0 is
   // the first cycle after START is taken). Mode 1 adds extra START
   // pulses inside VSYNC and DATA.
   task automatic capture(input int mode);
      logic        hs_prev;
      logic [47:0] last;
      vs_cnt = 0; vs_first = -1; hs_cnt = 0; burst_n = 0;
      done_k = -1; hold_err = 0; hs_prev = 1'b0; last = '0;
      pairs.delete();
      for (int i = 0; i < 8; i++) begin
         bstart[i] = -1;
         blen[i] = 0;
      end
      @(negedge HCLK); START = 1'b1;
      @(negedge HCLK); START = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (k > 0) @(negedge HCLK);
         if (k == 0) done_at0 = ctrl_done;
         if (VSYNC) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = k;
         end
         if (HSYNC) begin
            hs_cnt++;
            pairs.push_back(cur_pair());
            if (!hs_prev && burst_n < 8) begin
               bstart[burst_n] = k;
               burst_n++;
            end
            if (burst_n > 0) blen[burst_n-1]++;
            last = cur_pair();
         end else if (hs_cnt > 0 && cur_pair() !== last) begin
            hold_err++;
         end
         hs_prev = HSYNC;
         if (ctrl_done) begin
            done_k = k;
            break;
         end
         if (mode == 1) START = (k == 50 || k == 262);
      end
      START = 1'b0;
   endtask

   task automatic check_timing(input string tag);
      int bad;
      nchk++;
      if (done_k !== 925) begin
         nfail++;
         $display("FAIL %s done_cycle: got %0d want 925", tag, done_k);
      end
      nchk++;
      if (vs_cnt !== 100 || vs_first !== 0) begin
         nfail++;
         $display("FAIL %s vsync: got %0d cycles from %0d want 100 from 0",
                  tag, vs_cnt, vs_first);
      end
      nchk++;
      if (burst_n !== 5 || hs_cnt !== 25) begin
         nfail++;
         $display("FAIL %s bursts: got %0d bursts %0d cycles want 5/25",
                  tag, burst_n, hs_cnt);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (bstart[i] !== 260 + 165 * i || blen[i] !== 5) bad++;
      end
      nchk++;
      if (bad !== 0) begin
         nfail++;
         $display("FAIL %s burst_pos: got %0d bad bursts (first at %0d) want 0",
                  tag, bad, bstart[0]);
      end
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      START = 1'b0;
      repeat (3) @(negedge HCLK);
      nchk++;
      if ({VSYNC, HSYNC, ctrl_done} !== 3'b000) begin
         nfail++;
         $display("FAIL reset_ctrl: got %b want 000", {VSYNC, HSYNC, ctrl_done});
      end
      nchk++;
      if (cur_pair() !== 48'h0) begin
         nfail++;
         $display("FAIL reset_data: got %h want 0", cur_pair());
      end
      HRESET = 1'b0;
      repeat (3) @(negedge HCLK);
      nchk++;
      if ({VSYNC, HSYNC, ctrl_done} !== 3'b000) begin
         nfail++;
         $display("FAIL idle_ctrl: got %b want 000", {VSYNC, HSYNC, ctrl_done});
      end
   endtask

   task automatic test_frame_timing();
      capture(0);
      check_timing("frame");
      nchk++;
      if (hold_err !== 0) begin
         nfail++;
         $display("FAIL data_hold: got %0d changes want 0", hold_err);
      end
   endtask

   task automatic test_pixel_data();
      logic [47:0] f_exp, l_exp;
      int bad;
`ifdef IMAGE_READ_BRIGHTNESS_EN
      f_exp = 48'hAAABACADAEAF;
      l_exp = 48'h4A4B4C4D4E4F;
`else
      f_exp = 48'h78797A7B7C7D;
      l_exp = 48'h18191A1B1C1D;
`endif
      capture(0);
      nchk++;
      if (done_at0 !== 1'b0) begin
         nfail++;
         $display("FAIL replay_done_clear: got %b want 0", done_at0);
      end
      check_timing("replay");
      nchk++;
      if (pairs.size() !== 25) begin
         nfail++;
         $display("FAIL pair_count: got %0d want 25", pairs.size());
      end else begin
         nchk++;
         if (pairs[0] !== f_exp) begin
            nfail++;
            $display("FAIL first_pair: got %h want %h", pairs[0], f_exp);
         end
         nchk++;
         if (pairs[24] !== l_exp) begin
            nfail++;
            $display("FAIL last_pair: got %h want %h", pairs[24], l_exp);
         end
         bad = 0;
         for (int n = 0; n < 25; n++) begin
            if (pairs[n] !== exp_pair(n)) bad++;
         end
         nchk++;
         if (bad !== 0) begin
            nfail++;
            $display("FAIL all_pairs: got %0d wrong pairs want 0", bad);
         end
      end
   endtask

   task automatic test_start_ignored();
      int bad;
      capture(1);
      check_timing("extra_start");
      bad = 0;
      for (int n = 0; n < 25 && n < pairs.size(); n++) begin
         if (pairs[n] !== exp_pair(n)) bad++;
      end
      nchk++;
      if (bad !== 0 || pairs.size() !== 25) begin
         nfail++;
         $display("FAIL extra_start_data: got %0d wrong of %0d want 0 of 25",
                  bad, pairs.size());
      end
   endtask

   task automatic test_done_sticky();
      repeat (20) @(negedge HCLK);
      nchk++;
      if ({ctrl_done, HSYNC, VSYNC} !== 3'b100) begin
         nfail++;
         $display("FAIL done_sticky: got %b want 100", {ctrl_done, HSYNC, VSYNC});
      end
      nchk++;
      if (cur_pair() !== exp_pair(24)) begin
         nfail++;
         $display("FAIL done_hold: got %h want %h", cur_pair(), exp_pair(24));
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge HCLK); START = 1'b1;
      @(negedge HCLK); START = 1'b0;
      repeat (592) @(negedge HCLK);
      nchk++;
      if (HSYNC !== 1'b1 || cur_pair() !== exp_pair(12)) begin
         nfail++;
         $display("FAIL row2_pair: got hs=%b %h want hs=1 %h",
                  HSYNC, cur_pair(), exp_pair(12));
      end
      HRESET = 1'b1;
      #1;
      nchk++;
      if ({VSYNC, HSYNC, ctrl_done} !== 3'b000 || cur_pair() !== 48'h0) begin
         nfail++;
         $display("FAIL midreset_zero: got %b %h want 000 0",
                  {VSYNC, HSYNC, ctrl_done}, cur_pair());
      end
      @(negedge HCLK);
      HRESET = 1'b0;
      capture(0);
      check_timing("after_reset");
      nchk++;
      if (pairs.size() < 1 || pairs[0] !== exp_pair(0)) begin
         nfail++;
         $display("FAIL restart_row0: got %h want %h",
                  (pairs.size() > 0) ? pairs[0] : 48'hx, exp_pair(0));
      end
   endtask

   task automatic test_brightness();
      logic [23:0] want;
`ifdef IMAGE_READ_BRIGHTNESS_EN
      want = 24'h42FFFF;
`else
      want = 24'h10F0CD;
`endif
      tb_mem[120] = 8'h10; dut.mem[120] = 8'h10;
      tb_mem[121] = 8'hF0; dut.mem[121] = 8'hF0;
      tb_mem[122] = 8'hCD; dut.mem[122] = 8'hCD;
      capture(0);
      nchk++;
      if (pairs.size() < 1 || pairs[0][47:24] !== want) begin
         nfail++;
         $display("FAIL brightness: got %h want %h",
                  (pairs.size() > 0) ? pairs[0][47:24] : 24'hx, want);
      end
      load_ramp();
   endtask

   initial begin
      HRESET = 1'b1;
      START = 1'b0;
      load_ramp();
      test_reset();
      test_frame_timing();
      test_pixel_data();
      test_start_ignored();
      test_done_sticky();
      test_reset_mid_frame();
      test_brightness();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
